wb_stage: RTL

- Writeback stage of the MIPS datapath. Produces the write-side port of the register file: Wen, Wadr, Wdata.
- Takes a retiring instruction plus its ALU result and PC+4. For loads, it waits for memory read data, then aligns and extends it.
- It is the writer counterpart to the decode stage's register-file read path. Wadr, Wdata and Wen connect directly to the register-file write port.

---
 rtl/wb_stage.sv | 107 ++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: MIPS writeback stage; drives the register-file write port (Wen/Wadr/Wdata)
// with non-load results after one cycle and aligned load data after the memory returns it.
module wb_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      Ins,
  input  logic [31:0]      Result,
  input  logic [31:0]      PC4,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic             Wen,
  output logic [4:0]       Wadr,
  output logic [31:0]      Wdata,
  output logic             err,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic {IDLE, LOAD_WAIT} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t           r_state, w_next;
  logic             r_wen, r_err;
  logic [4:0]       r_wadr, r_rt;
  logic [31:0]      r_wdata;
  logic [CNT_W-1:0] r_retired;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [1:0]       r_off;
  logic [5:0]       w_op, w_funct;
  logic [4:0]       w_dst;
  logic [31:0]      w_data, w_ldata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic             w_accept, w_is_load, w_wr, w_mis, w_timeout, w_unused;
  assign w_op      = Ins[31:26];
  assign w_funct   = Ins[5:0];
  assign w_unused  = ^{Ins[25:21], Ins[10:6]};
  assign w_accept  = in_valid && in_ready;
  assign w_is_load = w_op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  assign w_wr      = w_op == 6'h03 || (w_op == 6'h00 && w_funct != 6'h08) || w_op[5:3] == 3'b001 || w_is_load;
  assign w_dst     = w_op == 6'h03 ? 5'd31 : w_op == 6'h00 ? Ins[15:11] : Ins[20:16];
  assign w_data    = (w_op == 6'h03 || (w_op == 6'h00 && w_funct == 6'h09)) ? PC4 : Result;
  assign w_mis     = ((w_op == 6'h21 || w_op == 6'h25) && Result[0]) || (w_op == 6'h23 && |Result[1:0]);
  assign w_timeout = r_cnt == CW'(TIMEOUT - 1);
  // r_op keeps only op[2:0]: bit 2 selects zero-extension, 2'b11 in [1:0] is LW, bit 0 is halfword
  assign w_byte    = mem_rdata[{r_off, 3'b000} +: 8];
  assign w_half    = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign w_ldata   = r_op[1:0] == 2'b11 ? mem_rdata :
                     r_op[0] ? {{16{w_half[15] & ~r_op[2]}}, w_half} :
                               {{24{w_byte[7] & ~r_op[2]}}, w_byte};
  always_ff @(posedge CLK)
    r_state <= RST ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE)
      w_next = (w_accept && w_is_load && !w_mis) ? LOAD_WAIT : IDLE;
    else
      w_next = (mem_rvalid || w_timeout) ? IDLE : LOAD_WAIT;
  end
  always_comb in_ready = r_state == IDLE && !RST;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wen     <= 1'b0;
      r_wadr    <= '0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
      r_retired <= '0;
      r_cnt     <= '0;
      r_rt      <= '0;
      r_op      <= '0;
      r_off     <= '0;
    end else begin
      r_wen <= 1'b0;
      if (w_accept && w_is_load && !w_mis) begin
        r_rt  <= Ins[20:16];
        r_op  <= w_op[2:0];
        r_off <= Result[1:0];
        r_cnt <= '0;
      end else if (w_accept) begin
        r_wen     <= w_wr && !w_mis && |w_dst;
        r_wadr    <= w_dst;
        r_wdata   <= w_data;
        r_retired <= r_retired + 1'b1;
        if (w_mis) r_err <= 1'b1;
      end else if (r_state == LOAD_WAIT) begin
        if (mem_rvalid) begin
          r_wen     <= |r_rt;
          r_wadr    <= r_rt;
          r_wdata   <= w_ldata;
          r_retired <= r_retired + 1'b1;
        end else if (w_timeout) begin
          r_err     <= 1'b1;
          r_retired <= r_retired + 1'b1;
        end else
          r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign Wen     = r_wen;
  assign Wadr    = r_wadr;
  assign Wdata   = r_wdata;
  assign err     = r_err;
  assign retired = r_retired;
endmodule
